// File: rtl/audio_mux_mc.sv
// ---------------------------------------------------------------------------
// audio_mux_mc
//   Multi-channel, FIFO-buffered audio register mux. Sits between the synth
//   voice engine and the CPU/JACK bridge: captures CHANNELS parallel samples
//   per synth frame into a frame-wide FIFO, exposes them through a 32-bit
//   register port, and paces the synth with trigger pulses, either
//   free-running from the I2S word clock or fill-to-level for JACK.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   address           register select (ADDR_WIDTH bits)
//   read / write      register strobes
//   datain            32-bit write data
//   dataout           registered read data, valid the cycle after read
//   sound_in          one frame, channel k at [k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]
//   sample_valid      one-cycle strobe, sound_in holds a complete frame
//   synth_idle        synth can accept a trigger
//   lrck              asynchronous I2S word clock
//   trig              frame trigger to the synth
//   i2s_enable        buffersize == 0 (free-running I2S pacing)
//   samplerate_is_48  samplerate register == 48000 (registered)
//   fifo_level        frames currently stored
//
// Register map
//   0 CTRL       W  bit0 jack_active, bit1 flush (self-clearing)
//   1 BUFSIZE    W  datain[FIFO_WIDTH:0], clamped to 2^FIFO_WIDTH
//   2 SAMPLERATE W  32 bits
//   3 STATUS     RW {overflow, underflow, full, empty, 0.., level};
//                   write 1 to bit31/bit30 clears that sticky flag
//   4+n CHn      R  head-frame sample n, left-justified; reading the last
//                   channel pops the frame
// ---------------------------------------------------------------------------
module audio_mux_mc #(
  parameter int CHANNELS      = 2,
  parameter int AUD_BIT_DEPTH = 24,
  parameter int FIFO_WIDTH    = 6,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic                              read,
  input  logic                              write,
  input  logic [31:0]                       datain,
  output logic [31:0]                       dataout,
  input  logic [CHANNELS*AUD_BIT_DEPTH-1:0] sound_in,
  input  logic                              sample_valid,
  input  logic                              synth_idle,
  input  logic                              lrck,
  output logic                              trig,
  output logic                              i2s_enable,
  output logic                              samplerate_is_48,
  output logic [FIFO_WIDTH:0]               fifo_level
);

  localparam int DEPTH   = 1 << FIFO_WIDTH;
  localparam int FRAME_W = CHANNELS * AUD_BIT_DEPTH;
  localparam int LVL_W   = FIFO_WIDTH + 1;

  localparam logic [LVL_W-1:0]      DEPTH_LVL   = LVL_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BUFSZ  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RATE   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = ADDR_WIDTH'(4 + CHANNELS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [FRAME_W-1:0]    mem_q [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [LVL_W-1:0]      pending_q, pending_d;
  logic [LVL_W-1:0]      buffersize_q, buffersize_d;
  logic [31:0]           samplerate_q, samplerate_d;
  logic                  rate48_q, rate48_d;
  logic                  jack_active_q, jack_active_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  lrck_s1_q, lrck_s1_d;
  logic                  lrck_s2_q, lrck_s2_d;
  logic                  trig_q, trig_d;
  logic [31:0]           dataout_q, dataout_d;

  // -------------------------------------------------------------------------
  // Register decode
  // -------------------------------------------------------------------------
  logic wr_ctrl, wr_bufsz, wr_rate, wr_status, flush;

  assign wr_ctrl   = write && (address == ADDR_CTRL);
  assign wr_bufsz  = write && (address == ADDR_BUFSZ);
  assign wr_rate   = write && (address == ADDR_RATE);
  assign wr_status = write && (address == ADDR_STATUS);
  assign flush     = wr_ctrl && datain[1];

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic fifo_empty, fifo_full, pop_req, push, pop, i2s_mode;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == DEPTH_LVL);
  assign pop_req    = read && (address == ADDR_LAST);
  // Level is taken before this cycle's push, so a pop against an empty
  // FIFO is an underflow even when a push lands in the same cycle.
  assign push       = sample_valid && !fifo_full;
  assign pop        = pop_req && !fifo_empty;
  assign i2s_mode   = (buffersize_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Frame storage needs no reset: the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) mem_q[wr_ptr_q] <= sound_in;
  end

  // -------------------------------------------------------------------------
  // Control registers and sticky flags
  // -------------------------------------------------------------------------
  always_comb begin
    jack_active_d = jack_active_q;
    buffersize_d  = buffersize_q;
    samplerate_d  = samplerate_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    if (wr_ctrl) jack_active_d = datain[0];
    if (wr_bufsz)
      buffersize_d = (datain[LVL_W-1:0] > DEPTH_LVL) ? DEPTH_LVL : datain[LVL_W-1:0];
    if (wr_rate) samplerate_d = datain;

    // A new event in the same cycle as the clearing write wins, so an
    // event is never lost.
    if (wr_status && datain[31]) overflow_d  = 1'b0;
    if (wr_status && datain[30]) underflow_d = 1'b0;
    if (sample_valid && fifo_full) overflow_d  = 1'b1;
    if (pop_req && fifo_empty)     underflow_d = 1'b1;
  end

  // Compare against the stored register so the flag lands two cycles after
  // the write and is cleanly registered.
  assign rate48_d = (samplerate_q == 32'd48000);

  // -------------------------------------------------------------------------
  // Trigger generation
  // -------------------------------------------------------------------------
  logic             jack_trig;
  logic [LVL_W:0]   outstanding;

  assign lrck_s1_d   = lrck;
  assign lrck_s2_d   = lrck_s1_q;
  assign jack_trig   = trig_q && !i2s_mode;
  // Frames stored plus frames already requested; one bit wider so the sum
  // cannot wrap.
  assign outstanding = {1'b0, level_q} + {1'b0, pending_q};

  always_comb begin
    if (i2s_mode)
      trig_d = lrck_s2_q;
    else
      // Requiring trig low the previous cycle limits the rate to one pulse
      // per two cycles and lets pending catch up before the next decision.
      trig_d = jack_active_q && synth_idle && !trig_q &&
               (outstanding < {1'b0, buffersize_q});
  end

  // Pending counts requests still unanswered. Leaving JACK mode (or a flush)
  // abandons them; a trig answered in its own cycle nets to zero.
  always_comb begin
    pending_d = pending_q;
    if (flush || !jack_active_q)
      pending_d = '0;
    else if (jack_trig && !sample_valid)
      pending_d = pending_q + 1'b1;
    else if (!jack_trig && sample_valid && (pending_q != '0))
      pending_d = pending_q - 1'b1;
  end

  // -------------------------------------------------------------------------
  // Read data
  // -------------------------------------------------------------------------
  logic [FRAME_W-1:0] head;
  logic [31:0]        chan_word;
  logic [31:0]        status_word;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    chan_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (address == ADDR_WIDTH'(4 + k))
        chan_word = 32'(head[k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]) << (32 - AUD_BIT_DEPTH);
    end

    status_word              = '0;
    status_word[31]          = overflow_q;
    status_word[30]          = underflow_q;
    status_word[29]          = fifo_full;
    status_word[28]          = fifo_empty;
    status_word[LVL_W-1:0]   = level_q;

    dataout_d = dataout_q;
    if (read) begin
      // chan_word is already zero for write-only and unmapped addresses.
      if (address == ADDR_STATUS) dataout_d = status_word;
      else if (fifo_empty)        dataout_d = '0;
      else                        dataout_d = chan_word;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      pending_q     <= '0;
      buffersize_q  <= '0;
      samplerate_q  <= '0;
      rate48_q      <= 1'b0;
      jack_active_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      lrck_s1_q     <= 1'b0;
      lrck_s2_q     <= 1'b0;
      trig_q        <= 1'b0;
      dataout_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      pending_q     <= pending_d;
      buffersize_q  <= buffersize_d;
      samplerate_q  <= samplerate_d;
      rate48_q      <= rate48_d;
      jack_active_q <= jack_active_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      lrck_s1_q     <= lrck_s1_d;
      lrck_s2_q     <= lrck_s2_d;
      trig_q        <= trig_d;
      dataout_q     <= dataout_d;
    end
  end

  assign dataout          = dataout_q;
  assign trig             = trig_q;
  assign i2s_enable       = i2s_mode;
  assign samplerate_is_48 = rate48_q;
  assign fifo_level       = level_q;

endmodule

// File: tb/tb_audio_mux_mc.sv
// Bench for audio_mux_mc (CHANNELS=2, AUD_BIT_DEPTH=24, FIFO_WIDTH=2).
// Register reads push their expected dataout into a scoreboard; a monitor
// compares dataout whenever a read strobe was taken on the previous edge.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_audio_mux_mc;
  localparam int CH  = 2;
  localparam int AW  = 24;
  localparam int FW  = 2;
  localparam int ADW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADW-1:0]    address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       datain = '0;
  logic [31:0]       dataout;
  logic [CH*AW-1:0]  sound_in = '0;
  logic              sample_valid = 1'b0;
  logic              synth_idle = 1'b0;
  logic              lrck = 1'b0;
  logic              trig;
  logic              i2s_enable;
  logic              samplerate_is_48;
  logic [FW:0]       fifo_level;

  always #5 clk = ~clk;

  audio_mux_mc #(.CHANNELS(CH), .AUD_BIT_DEPTH(AW), .FIFO_WIDTH(FW), .ADDR_WIDTH(ADW)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .datain(datain), .dataout(dataout), .sound_in(sound_in),
    .sample_valid(sample_valid), .synth_idle(synth_idle), .lrck(lrck),
    .trig(trig), .i2s_enable(i2s_enable), .samplerate_is_48(samplerate_is_48),
    .fifo_level(fifo_level)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  int          sn = 0;

  // ---------------- monitor ----------------
  logic        rd_d = 1'b0;
  logic [31:0] mon_exp;
  string       mon_nm;

  always @(posedge clk) rd_d <= read;

  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underrun: got %08h with no expected entry", dataout);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = nm_q.pop_front();
        checks++;
        if (dataout !== mon_exp) begin
          errors++;
          $display("FAIL %s: dataout got %08h expected %08h", mon_nm, dataout, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers (all entered and left at a falling edge) -------
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic o, input logic u, input logic f,
                                     input logic e, input logic [2:0] lv);
    return {o, u, f, e, 25'd0, lv};
  endfunction

  task automatic wr(input logic [ADW-1:0] a, input logic [31:0] d);
    address = a; datain = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [ADW-1:0] a, input logic [31:0] e, input string n);
    address = a; read = 1'b1;
    exp_q.push_back(e); nm_q.push_back(n);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    sound_in = {r, l}; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Count trig pulses for 'cycles' cycles; optionally answer each one with
  // sample_valid 'dly' cycles later (dly 0 = in the trig cycle itself).
  task automatic run_jack(input int cycles, input int dly, input bit answer, output int ntrig);
    int due[$];
    logic [23:0] l, r;
    ntrig = 0;
    for (int c = 0; c < cycles; c++) begin
      sample_valid = 1'b0;
      if (trig) begin
        ntrig++;
        if (answer) due.push_back(c + dly);
      end
      if (due.size() > 0 && due[0] == c) begin
        void'(due.pop_front());
        l = 24'h300000 + 24'(sn);
        r = 24'h400000 + 24'(sn);
        sound_in = {r, l};
        sample_valid = 1'b1;
        sn++;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  task automatic lrck_edge(input logic v, input string n);
    int k;
    lrck = v;
    k = 0;
    while (trig !== v && k < 10) begin
      @(negedge clk);
      k++;
    end
    // lrck moves mid-cycle, so two sync flops plus the trig flop put the
    // trig edge on the third falling edge (2.5 clk after lrck).
    chk(n, k, 3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_dataout", dataout, 32'h0);
    chk("rst_trig", {31'd0, trig}, 32'd0);
    chk("rst_i2s_enable", {31'd0, i2s_enable}, 32'd1);
    chk("rst_rate48", {31'd0, samplerate_is_48}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rd(3, st(0, 0, 0, 1, 0), "rst_status");

    // I2S pacing follows lrck
    lrck_edge(1'b1, "i2s_rise_delay");
    repeat (3) @(negedge clk);
    lrck_edge(1'b0, "i2s_fall_delay");
    chk("i2s_level", {29'd0, fifo_level}, 32'd0);

    // Basic frame: left-justified channel reads, pop on last channel
    push(24'h123456, 24'hABCDEF);
    chk("frame_level_push", {29'd0, fifo_level}, 32'd1);
    rd(4, 32'h12345600, "frame_ch0");
    chk("frame_level_ch0", {29'd0, fifo_level}, 32'd1);
    rd(5, 32'hABCDEF00, "frame_ch1");
    chk("frame_level_ch1", {29'd0, fifo_level}, 32'd0);

    // Empty / unmapped reads and underflow
    rd(4, 32'h0, "empty_ch0");
    rd(7, 32'h0, "unmapped_7");
    rd(0, 32'h0, "writeonly_ctrl");
    rd(5, 32'h0, "underflow_ch1");
    rd(3, st(0, 1, 0, 1, 0), "status_underflow");
    wr(3, 32'h4000_0000);
    rd(3, st(0, 0, 0, 1, 0), "status_unf_clear");

    // Overflow: 5 frames into a 4-deep FIFO
    for (int k = 0; k < 5; k++) push(24'h100000 + 24'(k), 24'h200000 + 24'(k));
    chk("ovf_level", {29'd0, fifo_level}, 32'd4);
    rd(3, st(1, 0, 1, 0, 4), "status_overflow_full");
    wr(3, 32'h8000_0000);
    rd(3, st(0, 0, 1, 0, 4), "status_ovf_clear");
    rd(4, 32'h10000000, "ovf_head_ch0");
    rd(5, 32'h20000000, "ovf_head_ch1");
    rd(5, 32'h20000100, "ovf_f1_ch1");
    chk("pp_level_before", {29'd0, fifo_level}, 32'd2);
    // push and pop in the same cycle at level 2
    address = 5; read = 1'b1; exp_q.push_back(32'h20000200); nm_q.push_back("pp_pop_f2");
    sound_in = {24'h200005, 24'h100005}; sample_valid = 1'b1;
    @(negedge clk);
    read = 1'b0; sample_valid = 1'b0;
    chk("pp_level_after", {29'd0, fifo_level}, 32'd2);
    rd(3, st(0, 0, 0, 0, 2), "pp_status");
    rd(4, 32'h10000300, "order_f3_ch0");
    rd(5, 32'h20000300, "order_f3_ch1");
    rd(5, 32'h20000500, "order_f5_ch1");
    chk("order_level", {29'd0, fifo_level}, 32'd0);
    push(24'h0000AA, 24'h0000BB);
    wr(0, 32'h2);
    chk("flush_level", {29'd0, fifo_level}, 32'd0);
    rd(3, st(0, 0, 0, 1, 0), "flush_status");

    // JACK mode: fill to BUFSIZE=4, answers 3 cycles late
    wr(1, 32'd4);
    chk("jack_i2s_enable", {31'd0, i2s_enable}, 32'd0);
    synth_idle = 1'b1;
    wr(0, 32'h1);
    run_jack(60, 3, 1'b1, n);
    chk("jack_trigs", n, 4);
    chk("jack_level", {29'd0, fifo_level}, 32'd4);
    rd(5, 32'h40000000, "jack_pop");
    run_jack(20, 3, 1'b1, n);
    chk("jack_refill_trigs", n, 1);
    chk("jack_refill_level", {29'd0, fifo_level}, 32'd4);

    // trig answered in its own cycle: pending must not grow
    synth_idle = 1'b0;
    wr(0, 32'h3);
    synth_idle = 1'b1;
    run_jack(40, 0, 1'b1, n);
    chk("same_cycle_trigs", n, 4);
    chk("same_cycle_level", {29'd0, fifo_level}, 32'd4);

    // Cycle end with pending = 2
    synth_idle = 1'b0;
    wr(0, 32'h3);
    synth_idle = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk);
      if (trig) n++;
    end
    chk("cycend_pending_trigs", n, 2);
    synth_idle = 1'b0;
    wr(0, 32'h0);
    synth_idle = 1'b1;
    run_jack(20, 0, 1'b0, n);
    chk("cycend_no_trig", n, 0);
    wr(0, 32'h1);
    run_jack(30, 0, 1'b0, n);
    chk("cycend_pending_cleared", n, 4);
    synth_idle = 1'b0;
    wr(0, 32'h2);

    // BUFSIZE clamp: 7 -> 4
    wr(1, 32'd7);
    wr(0, 32'h1);
    synth_idle = 1'b1;
    run_jack(60, 3, 1'b1, n);
    chk("clamp_trigs", n, 4);
    chk("clamp_level", {29'd0, fifo_level}, 32'd4);
    synth_idle = 1'b0;
    wr(0, 32'h2);
    wr(1, 32'd0);
    chk("clamp_back_i2s", {31'd0, i2s_enable}, 32'd1);

    // SAMPLERATE flag, two cycles after the write
    wr(2, 32'd48000);
    chk("rate48_t1", {31'd0, samplerate_is_48}, 32'd0);
    @(negedge clk);
    chk("rate48_t2", {31'd0, samplerate_is_48}, 32'd1);
    wr(2, 32'd44100);
    chk("rate441_t1", {31'd0, samplerate_is_48}, 32'd1);
    @(negedge clk);
    chk("rate441_t2", {31'd0, samplerate_is_48}, 32'd0);
    wr(2, 32'd48000);
    repeat (2) @(negedge clk);

    // Reset in mid-operation
    push(24'hAAAAAA, 24'h555555);
    push(24'h111111, 24'h222222);
    wr(1, 32'd2);
    rd(4, 32'hAAAAAA00, "premid_ch0");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_level", {29'd0, fifo_level}, 32'd0);
    chk("mid_i2s_enable", {31'd0, i2s_enable}, 32'd1);
    chk("mid_dataout", dataout, 32'h0);
    chk("mid_rate48", {31'd0, samplerate_is_48}, 32'd0);
    rd(3, st(0, 0, 0, 1, 0), "mid_status");
    rd(4, 32'h0, "mid_ch0_empty");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
